ad1939_dac_tx: RTL and testbench

//  Serializes parallel left/right audio samples from the fabric's Avalon-ST stream onto AD1939 DAC pins
//  (DSDATA1 / DBCLK / DLRCLK) in I2S format. The block is the bus master: it generates DBCLK and DLRCLK from MCLK.
//  It is the transmit counterpart of the ADC capture path (ASDATA2 / ABCLK / ALRCLK) and sits between the

---
 rtl/ad1939_dac_tx.sv | 212 +++++++++++++++++++++
 tb/tb_ad1939_dac_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad1939_dac_tx.sv
// ad1939_dac_tx
//
// Purpose:
//    I2S transmitter for the AD1939 DAC port. Takes left/right samples from an
//    Avalon-ST sink, double-buffers them as a pair, and shifts them out MSB-first
//    on DSDATA1 while generating DBCLK and DLRCLK from MCLK (this block is the
//    bus master). Each sample sits left-justified in a SLOT_W-bit slot, delayed
//    by one DBCLK after the DLRCLK edge.
//
// Ports:
//    clk                in   1       codec MCLK, the only clock
//    reset              in   1       synchronous, active-high
//    data_sink_data     in   DATA_W  two's complement sample
//    data_sink_channel  in   1       0 = left, 1 = right
//    data_sink_valid    in   1       beat valid
//    data_sink_ready    out  1       beat accepted when valid & ready
//    dsdata             out  1       serial data, changes on DBCLK falling edge
//    dbclk              out  1       bit clock, BCLK_DIV clk per period
//    dlrclk             out  1       frame clock, 0 = left slot, 1 = right slot
//    underrun           out  1       1-cycle pulse when a frame starts without a full pair
//    underrun_count     out  16      saturating underrun counter (only with the macro below)
//
// Configuration:
//    AD1939_TX_UNDERRUN_CNT_EN  when defined, adds the underrun_count port and counter.

module ad1939_dac_tx #(
   parameter int DATA_W   = 24,
   parameter int SLOT_W   = 32,
   parameter int BCLK_DIV = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_sink_data,
   input  logic              data_sink_channel,
   input  logic              data_sink_valid,
   output logic              data_sink_ready,
   output logic              dsdata,
   output logic              dbclk,
   output logic              dlrclk,
   output logic              underrun
`ifdef AD1939_TX_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       underrun_count
`endif
);

   localparam int DIV_W   = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
   localparam int FRAME_W = 2 * SLOT_W;
   localparam int BIT_W   = $clog2(FRAME_W);
   localparam int IDX_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(BCLK_DIV / 2);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_W - 1);
   localparam logic [BIT_W-1:0] SLOT_START = BIT_W'(SLOT_W);
   localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W);

   logic [DIV_W-1:0]  divCntQ, divCntD;
   logic [BIT_W-1:0]  bitCntQ, bitCntD;
   logic              dbclkQ, dbclkD;
   logic              dlrclkQ, dlrclkD;
   logic              dsdataQ, dsdataD;
   logic              underrunQ, underrunD;
   logic [DATA_W-1:0] stageLQ, stageLD, stageRQ, stageRD;
   logic [DATA_W-1:0] activeLQ, activeLD, activeRQ, activeRD;
   logic              fullLQ, fullLD, fullRQ, fullRD;

   logic              tick;
   logic              frameEnd;
   logic              pairReady;
   logic              accept;
   logic [BIT_W-1:0]  slotBit;
   logic [IDX_W-1:0]  sampleIdx;
   logic [DATA_W-1:0] activeSample;

   // Timing strobes and the sink handshake. tick marks the last MCLK of a
   // DBCLK period; frameEnd is the tick that closes the right slot. Ready only
   // depends on whether a complete pair is already waiting, so a producer can
   // always top up a half-filled pair (or overwrite a stale channel).
   always_comb begin
      tick            = (divCntQ == DIV_LAST);
      frameEnd        = tick && (bitCntQ == BIT_LAST);
      pairReady       = fullLQ && fullRQ;
      data_sink_ready = ~reset & ~pairReady;
      accept          = data_sink_valid & data_sink_ready;
   end

   // Bit clock and serializer. DBCLK is low for the first half of each period
   // and high for the second, so its falling edge lines up with the divider
   // wrap; DLRCLK and DSDATA move on that same edge and are stable when the
   // codec samples on the next rising edge. Slot bit 0 is the I2S one-bit
   // delay, and bits past the sample width are padded with zeros.
   always_comb begin
      divCntD      = tick ? '0 : divCntQ + 1'b1;
      dbclkD       = (divCntD >= DIV_HALF);
      bitCntD      = bitCntQ;
      dlrclkD      = dlrclkQ;
      dsdataD      = dsdataQ;
      slotBit      = '0;
      sampleIdx    = '0;
      activeSample = '0;
      if (tick) begin
         bitCntD      = (bitCntQ == BIT_LAST) ? '0 : bitCntQ + 1'b1;
         dlrclkD      = (bitCntD >= SLOT_START);
         slotBit      = dlrclkD ? (bitCntD - SLOT_START) : bitCntD;
         activeSample = dlrclkD ? activeRQ : activeLQ;
         sampleIdx    = IDX_W'(DATA_LAST - slotBit);
         if ((slotBit == '0) || (slotBit > DATA_LAST)) begin
            dsdataD = 1'b0;
         end else begin
            dsdataD = activeSample[sampleIdx];
         end
      end
   end

   // Sample staging. At each frame boundary a complete pair moves into the
   // active registers; without one, the previous pair simply plays again and
   // a lone staged channel keeps waiting for its partner. The boundary uses
   // the stage contents from before any same-cycle write, and a write always
   // leaves its channel marked full, so a beat landing on the boundary is kept
   // for the following frame.
   always_comb begin
      stageLD   = stageLQ;
      stageRD   = stageRQ;
      fullLD    = fullLQ;
      fullRD    = fullRQ;
      activeLD  = activeLQ;
      activeRD  = activeRQ;
      underrunD = 1'b0;
      if (frameEnd) begin
         if (pairReady) begin
            activeLD = stageLQ;
            activeRD = stageRQ;
            fullLD   = 1'b0;
            fullRD   = 1'b0;
         end else begin
            underrunD = 1'b1;
         end
      end
      if (accept) begin
         if (data_sink_channel) begin
            stageRD = data_sink_data;
            fullRD  = 1'b1;
         end else begin
            stageLD = data_sink_data;
            fullLD  = 1'b1;
         end
      end
   end

   // State registers. A reset mid-frame drops the frame in progress and
   // restarts the next one from the first bit of the left slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         divCntQ   <= '0;
         bitCntQ   <= '0;
         dbclkQ    <= 1'b0;
         dlrclkQ   <= 1'b0;
         dsdataQ   <= 1'b0;
         underrunQ <= 1'b0;
         stageLQ   <= '0;
         stageRQ   <= '0;
         activeLQ  <= '0;
         activeRQ  <= '0;
         fullLQ    <= 1'b0;
         fullRQ    <= 1'b0;
      end else begin
         divCntQ   <= divCntD;
         bitCntQ   <= bitCntD;
         dbclkQ    <= dbclkD;
         dlrclkQ   <= dlrclkD;
         dsdataQ   <= dsdataD;
         underrunQ <= underrunD;
         stageLQ   <= stageLD;
         stageRQ   <= stageRD;
         activeLQ  <= activeLD;
         activeRQ  <= activeRD;
         fullLQ    <= fullLD;
         fullRQ    <= fullRD;
      end
   end

   assign dsdata   = dsdataQ;
   assign dbclk    = dbclkQ;
   assign dlrclk   = dlrclkQ;
   assign underrun = underrunQ;

`ifdef AD1939_TX_UNDERRUN_CNT_EN
   logic [15:0] underrunCountQ, underrunCountD;

   // Underrun counter for software to poll. It advances together with the
   // pulse and sticks at all-ones instead of wrapping back to a small value.
   always_comb begin
      underrunCountD = underrunCountQ;
      if (underrunD && (underrunCountQ != 16'hFFFF)) begin
         underrunCountD = underrunCountQ + 16'd1;
      end
   end

   // Counter register, cleared with the rest of the block.
   always_ff @(posedge clk) begin
      if (reset) begin
         underrunCountQ <= '0;
      end else begin
         underrunCountQ <= underrunCountD;
      end
   end

   assign underrun_count = underrunCountQ;
`endif

endmodule

// File: tb/tb_ad1939_dac_tx.sv
// tb_ad1939_dac_tx
//
// Drives sample pairs into ad1939_dac_tx and checks the I2S pin stream frame
// by frame against a queue of expected frames, plus the DBCLK/DLRCLK phase
// against the MCLK count since reset.

module tb_ad1939_dac_tx;

   localparam int DATA_W = 24;

   typedef struct {
      logic [23:0] left;
      logic [23:0] right;
      int          underruns;
   } frame_t;

   logic              clk               = 1'b0;
   logic              reset             = 1'b1;
   logic [DATA_W-1:0] data_sink_data    = '0;
   logic              data_sink_channel = 1'b0;
   logic              data_sink_valid   = 1'b0;
   logic              data_sink_ready;
   logic              dsdata;
   logic              dbclk;
   logic              dlrclk;
   logic              underrun;
`ifdef AD1939_TX_UNDERRUN_CNT_EN
   logic [15:0]       underrun_count;
`endif

   int          checks   = 0;
   int          errors   = 0;
   int          cyc      = 0;
   logic        rstQ     = 1'b1;
   frame_t      expQ[$];
   logic [63:0] capBits  = '0;
   int          idx      = 0;
   int          uCnt     = 0;
   logic        prevBclk = 1'b0;
   int          acc      = 0;

   ad1939_dac_tx dut (
      .clk               (clk),
      .reset             (reset),
      .data_sink_data    (data_sink_data),
      .data_sink_channel (data_sink_channel),
      .data_sink_valid   (data_sink_valid),
      .data_sink_ready   (data_sink_ready),
      .dsdata            (dsdata),
      .dbclk             (dbclk),
      .dlrclk            (dlrclk),
      .underrun          (underrun)
`ifdef AD1939_TX_UNDERRUN_CNT_EN
      ,
      .underrun_count    (underrun_count)
`endif
   );

   // 100 MHz-style free-running MCLK.
   always #5 clk = ~clk;

   // MCLK count since the last reset edge, and whether the DUT was in reset
   // at the most recent edge.
   always @(posedge clk) begin
      rstQ <= reset;
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pushFrame(input logic [23:0] l, input logic [23:0] r, input int u);
      frame_t f;
      f.left      = l;
      f.right     = r;
      f.underruns = u;
      expQ.push_back(f);
   endtask

   // Advance to 1 time unit after the edge that brings cyc to target.
   task automatic waitUntil(input int target);
      int guard = 0;
      while (cyc != target && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      checkOutput("wait_reached", 64'(cyc), 64'(target));
   endtask

   // Present one beat and hold it until the handshake completes; accEdge is
   // the cycle count of the accepting edge.
   task automatic applyStimulus(input logic ch, input logic [23:0] data, output int accEdge);
      logic accepted = 1'b0;
      int   guard    = 0;
      data_sink_channel = ch;
      data_sink_data    = data;
      data_sink_valid   = 1'b1;
      while (!accepted && guard < 2000) begin
         @(negedge clk);
         accepted = data_sink_ready;
         @(posedge clk);
         #1;
         guard++;
      end
      accEdge         = cyc;
      data_sink_valid = 1'b0;
      checkOutput("beat_accepted", 64'(accepted), 64'd1);
   endtask

   // Pin monitor: reset values, clock phase, and frame deserialization.
   initial begin
      frame_t f;
      forever begin
         @(negedge clk);
         if (reset) checkOutput("ready_in_reset", 64'(data_sink_ready), 64'd0);
         if (rstQ) begin
            checkOutput("pins_in_reset", 64'({dbclk, dlrclk, dsdata, underrun}), 64'd0);
            idx      = 0;
            uCnt     = 0;
            prevBclk = 1'b0;
         end else begin
            checkOutput("dbclk_phase", 64'(dbclk), 64'((cyc % 4) >= 2));
            checkOutput("dlrclk_phase", 64'(dlrclk), 64'(((cyc / 4) % 64) >= 32));
            if (underrun === 1'b1) uCnt++;
            if (dbclk === 1'b1 && prevBclk === 1'b0) begin
               capBits = {capBits[62:0], dsdata};
               idx++;
               if (idx == 64) begin
                  if (expQ.size() > 0) begin
                     f = expQ.pop_front();
                     checkOutput("frame_bits", capBits, {1'b0, f.left, 7'b0, 1'b0, f.right, 7'b0});
                     checkOutput("frame_underruns", 64'(uCnt), 64'(f.underruns));
                  end
                  idx  = 0;
                  uCnt = 0;
               end
            end
            prevBclk = dbclk;
         end
      end
   end

   // Directed sequence.
   initial begin
      $display("[TB] start");
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      // Reset in the middle of a frame.
      waitUntil(100);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("ready_after_reset", 64'(data_sink_ready), 64'd1);
`ifdef AD1939_TX_UNDERRUN_CNT_EN
      checkOutput("ucount_reset", 64'(underrun_count), 64'd0);
`endif
      pushFrame(24'h0, 24'h0, 0);

      // First pair.
      waitUntil(20);
      applyStimulus(1'b0, 24'hA5A5A5, acc);
      applyStimulus(1'b1, 24'h5A5A5A, acc);
      @(negedge clk);
      checkOutput("ready_pair_full", 64'(data_sink_ready), 64'd0);
      pushFrame(24'hA5A5A5, 24'h5A5A5A, 0);

      waitUntil(259);
      @(negedge clk);
      checkOutput("latency_slot_bit0", 64'(dsdata), 64'd0);
      waitUntil(260);
      @(negedge clk);
      checkOutput("latency_msb", 64'(dsdata), 64'd1);
      checkOutput("ready_after_load", 64'(data_sink_ready), 64'd1);
`ifdef AD1939_TX_UNDERRUN_CNT_EN
      checkOutput("ucount_before", 64'(underrun_count), 64'd0);
`endif

      // No beats for a whole frame: previous pair repeats.
      pushFrame(24'hA5A5A5, 24'h5A5A5A, 1);
      waitUntil(520);
`ifdef AD1939_TX_UNDERRUN_CNT_EN
      @(negedge clk);
      checkOutput("ucount_one", 64'(underrun_count), 64'd1);
`endif

      // Third beat waits for the frame boundary.
      waitUntil(600);
      applyStimulus(1'b0, 24'h0F0F0F, acc);
      applyStimulus(1'b1, 24'h3C3C3C, acc);
      @(negedge clk);
      checkOutput("ready_second_pair", 64'(data_sink_ready), 64'd0);
      pushFrame(24'h0F0F0F, 24'h3C3C3C, 0);
      applyStimulus(1'b0, 24'h777777, acc);
      checkOutput("held_beat_edge", 64'(acc), 64'd769);
      pushFrame(24'h0F0F0F, 24'h3C3C3C, 1);

      // Overwrite the lone left, then a beat presented on the boundary cycle.
      waitUntil(1100);
      applyStimulus(1'b0, 24'h111111, acc);
      applyStimulus(1'b1, 24'h222222, acc);
      pushFrame(24'h111111, 24'h222222, 0);
      waitUntil(1279);
      applyStimulus(1'b0, 24'h123456, acc);
      checkOutput("boundary_beat_edge", 64'(acc), 64'd1281);
      @(negedge clk);
      checkOutput("ready_lone_left", 64'(data_sink_ready), 64'd1);
      pushFrame(24'h111111, 24'h222222, 1);

      // Partner for the held 123456.
      waitUntil(1600);
      applyStimulus(1'b1, 24'h654321, acc);
      pushFrame(24'h123456, 24'h654321, 0);

      waitUntil(2060);
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
`ifdef AD1939_TX_UNDERRUN_CNT_EN
      checkOutput("ucount_final", 64'(underrun_count), 64'd4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
